// File: rtl/final_mux.sv
// Registered 4:1 write-back selector: loads RS1, IMMVAL, DOUT_DM or ALUOUT
// into MUX_OUT according to the opcode, or holds the previous value.
module final_mux #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OPC_W  = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] RS1,
   input  logic [DATA_W-1:0] IMMVAL,
   input  logic [DATA_W-1:0] DOUT_DM,
   input  logic [DATA_W-1:0] ALUOUT,
   input  logic [OPC_W-1:0]  OPC,
   output logic [DATA_W-1:0] MUX_OUT
);

   localparam logic [OPC_W-1:0] OPC_MOV     = OPC_W'(4);
   localparam logic [OPC_W-1:0] OPC_LDI     = OPC_W'(5);
   localparam logic [OPC_W-1:0] OPC_LD      = OPC_W'(16);
   localparam logic [OPC_W-1:0] OPC_ALU_MAX = OPC_W'(15);

   logic [DATA_W-1:0] mux_nxt;

   // Source select; unknown or unlisted opcodes keep the current value
   always_comb begin
      mux_nxt = MUX_OUT;
      case (OPC)
         OPC_MOV: mux_nxt = RS1;
         OPC_LDI: mux_nxt = IMMVAL;
         OPC_LD:  mux_nxt = DOUT_DM;
         default: begin
            if (OPC <= OPC_ALU_MAX) begin
               mux_nxt = ALUOUT;
            end
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         MUX_OUT <= '0;
      end else begin
         MUX_OUT <= mux_nxt;
      end
   end

endmodule

// File: tb/tb_final_mux.sv
// Directed bench for final_mux: literal expectations per step plus a
// per-cycle comparison against an opcode-table reference model.
module tb_final_mux;

   logic        clock;
   logic        reset;
   logic [31:0] RS1;
   logic [31:0] IMMVAL;
   logic [31:0] DOUT_DM;
   logic [31:0] ALUOUT;
   logic [5:0]  OPC;
   logic [31:0] MUX_OUT;

   int unsigned asserts  = 0;
   int unsigned failures = 0;

   logic [31:0] model_out;
   bit          model_live = 0;

   final_mux #(.DATA_W(32), .OPC_W(6)) dut (
      .clock   (clock),
      .reset   (reset),
      .RS1     (RS1),
      .IMMVAL  (IMMVAL),
      .DOUT_DM (DOUT_DM),
      .ALUOUT  (ALUOUT),
      .OPC     (OPC),
      .MUX_OUT (MUX_OUT)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference: what write-back value the opcode table demands
   function automatic logic [31:0] ref_next(input logic [5:0] opc,
                                            input logic [31:0] prev);
      int o;
      o = int'(opc);
      if (o == 4)       return RS1;
      else if (o == 5)  return IMMVAL;
      else if (o == 16) return DOUT_DM;
      else if (o < 16)  return ALUOUT;
      else              return prev;
   endfunction

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         model_out  <= 32'd0;
         model_live <= 1'b1;
      end else if (model_live) begin
         model_out <= ref_next(OPC, model_out);
      end
   end

   // Cycle-by-cycle comparison, away from the active edge
   always @(negedge clock) begin
      if (model_live) begin
         asserts++;
         if (MUX_OUT !== model_out) begin
            failures++;
            $display("FAIL model_cmp t=%0t: MUX_OUT=%h model=%h", $time, MUX_OUT, model_out);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] exp);
      asserts++;
      if (MUX_OUT !== exp) begin
         failures++;
         $display("FAIL %s t=%0t: MUX_OUT=%h expected=%h", name, $time, MUX_OUT, exp);
      end
   endtask

   // Entered at posedge+2: drive OPC, confirm no combinational path, then
   // check the loaded value after each of the two edges it is held for
   task automatic apply(input string name, input logic [5:0] opc,
                        input logic [31:0] exp_old, input logic [31:0] exp_new);
      OPC = opc;
      #1 check({name, "_pre"}, exp_old);
      @(posedge clock);
      #1 check({name, "_e1"}, exp_new);
      @(posedge clock);
      #1 check({name, "_e2"}, exp_new);
      #1;
   endtask

   initial begin
      reset   = 1'b0;
      RS1     = 32'd1;
      IMMVAL  = 32'd2;
      DOUT_DM = 32'd3;
      ALUOUT  = 32'd5;
      OPC     = 6'b100000;

      // Reset acts without a clock edge
      #1 reset = 1'b1;
      #1 check("reset_async", 32'd0);
      @(posedge clock);
      @(posedge clock);
      #2 reset = 1'b0;
      apply("release_hold", 6'b100000, 32'd0, 32'd0);

      apply("ldi", 6'b000101, 32'd0, 32'd2);
      apply("ld",  6'b010000, 32'd2, 32'd3);
      apply("mov", 6'b000100, 32'd3, 32'd1);
      apply("alu", 6'b001100, 32'd1, 32'd5);

      ALUOUT = 32'd9;
      apply("hold_3f", 6'b111111, 32'd5, 32'd5);

      // Reset between edges while a selection is pending
      OPC = 6'b001100;
      reset = 1'b1;
      #1 check("reset_mid", 32'd0);
      @(posedge clock);
      #1 check("reset_held", 32'd0);
      #1 reset = 1'b0;
      #1 check("reset_rel_pre", 32'd0);
      @(posedge clock);
      #1 check("reset_rel_e1", 32'd9);
      #1;

      // Boundaries of the decode table and bit-exact passing
      apply("hold_11", 6'b010001, 32'd9, 32'd9);
      ALUOUT = 32'hDEAD_BEEF;
      apply("alu_0f", 6'b001111, 32'd9, 32'hDEAD_BEEF);
      ALUOUT = 32'h8000_0001;
      apply("alu_00", 6'b000000, 32'hDEAD_BEEF, 32'h8000_0001);
      ALUOUT = 32'h0000_0033;
      apply("alu_03", 6'b000011, 32'h8000_0001, 32'h0000_0033);
      ALUOUT = 32'h0000_0066;
      apply("alu_06", 6'b000110, 32'h0000_0033, 32'h0000_0066);
      RS1 = 32'hFFFF_FFFF;
      apply("mov_ff", 6'b000100, 32'h0000_0066, 32'hFFFF_FFFF);
      DOUT_DM = 32'h1234_5678;
      apply("hold_20", 6'b100000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      apply("ld_data", 6'b010000, 32'hFFFF_FFFF, 32'h1234_5678);

      @(posedge clock);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
